// File: rtl/rr_arb_2x1.sv
// rr_arb_2x1: two-input round-robin arbiter with a single registered output
// stage. It drives the downstream 2:1 mux select and keeps saturating
// per-input grant counters for debug.
module rr_arb_2x1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             r_prio;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_src;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_sel;
    logic             w_space;
    logic             w_accept;
    logic             w_acc0;
    logic             w_acc1;
    logic [WIDTH-1:0] w_gnt_data;

    // Grant: a lone requester wins; on a tie or when idle, prio decides.
    always_comb begin
        w_sel = r_prio;
        if (in0_valid && !in1_valid)
            w_sel = 1'b0;
        else if (in1_valid && !in0_valid)
            w_sel = 1'b1;
    end

    // The register can take a beat when empty or when it drains this cycle.
    // Ready goes only to the granted input, independent of its valid.
    assign w_space    = ~r_out_valid | out_ready;
    assign w_accept   = w_space & (in0_valid | in1_valid);
    assign w_acc0     = w_accept & ~w_sel;
    assign w_acc1     = w_accept & w_sel;
    assign w_gnt_data = w_sel ? in1_data : in0_data;

    assign sel       = w_sel;
    assign in0_ready = w_space & ~w_sel;
    assign in1_ready = w_space & w_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;

    // Output stage and priority: load on accept and hand the tie to the
    // loser; otherwise drop valid on drain and hold payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 1'b0;
            r_prio      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_src   <= w_sel;
            r_prio      <= ~w_sel;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Grant counters: clear beats a same-cycle increment; saturate at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (cnt_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_acc0 && r_cnt0 != CNT_MAX)
                r_cnt0 <= r_cnt0 + 1'b1;
            if (w_acc1 && r_cnt1 != CNT_MAX)
                r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_2x1.sv
// tb_rr_arb_2x1: scoreboard bench for rr_arb_2x1. A reference model at the
// handshake level predicts grants and pushes expected beats; a monitor pops
// and compares whenever the output holds a beat. A second instance with
// CNT_W=2 shares all inputs to exercise counter saturation.
module tb_rr_arb_2x1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in0_valid = 1'b0, in1_valid = 1'b0;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic         out_ready = 1'b0;
    logic         cnt_clr = 1'b0;

    logic         in0_ready, in1_ready, sel, out_valid, out_src;
    logic [W-1:0] out_data;
    logic [15:0]  cnt0, cnt1;

    logic         s_in0_ready, s_in1_ready, s_sel, s_out_valid, s_out_src;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_cnt0, s_cnt1;

    rr_arb_2x1 #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1), .cnt_clr(cnt_clr));

    rr_arb_2x1 #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
        .sel(s_sel), .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
        .out_ready(out_ready), .cnt0(s_cnt0), .cnt1(s_cnt1), .cnt_clr(cnt_clr));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source beat queues and expected output beats {src, data}.
    logic [W-1:0] sq0[$], sq1[$];
    logic [W:0]   q[$];
    bit           log_src[$];
    bit           gap_en = 1'b0;

    // Reference model state.
    bit           m_prio, m_full, pend, pacc0, pacc1;
    logic [W:0]   pbeat;
    int           m_c0, m_c1, m_s0, m_s1;
    int           run_len, max_run;

    // Reset empties everything the model holds.
    always @(negedge rst_n) begin
        q.delete();
        m_prio = 0; m_full = 0; pend = 0; pacc0 = 0; pacc1 = 0;
        m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    end

    // Model, combinational view: predict grant and readiness from the
    // requesters and the round-robin turn; check against both instances.
    always @(negedge clk) begin
        bit e_sel, space, acc;
        if (!rst_n) begin
            pend = 0; pacc0 = 0; pacc1 = 0;
        end else begin
            if (in0_valid != in1_valid) e_sel = in1_valid;
            else                        e_sel = m_prio;
            space = !m_full || out_ready;
            acc   = space && (in0_valid || in1_valid);
            chk("sel", sel, e_sel);
            chk("in0_ready", in0_ready, space && !e_sel);
            chk("in1_ready", in1_ready, space && e_sel);
            chk("s_sel", s_sel, e_sel);
            chk("cnt0", cnt0, m_c0);
            chk("cnt1", cnt1, m_c1);
            chk("s_cnt0", s_cnt0, m_s0);
            chk("s_cnt1", s_cnt1, m_s1);
            pend  = acc;
            pbeat = {e_sel, e_sel ? in1_data : in0_data};
            pacc0 = acc && !e_sel;
            pacc1 = acc && e_sel;
        end
    end

    // Model, clock edge: commit the predicted transfer.
    always @(posedge clk) begin
        if (rst_n) begin
            if (pend) begin
                q.push_back(pbeat);
                m_prio = !pbeat[W];
                m_full = 1;
            end else if (out_ready) begin
                m_full = 0;
            end
            if (cnt_clr) begin
                m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
            end else begin
                if (pacc0) begin
                    m_c0 = (m_c0 < 65535) ? m_c0 + 1 : m_c0;
                    m_s0 = (m_s0 < 3) ? m_s0 + 1 : m_s0;
                end
                if (pacc1) begin
                    m_c1 = (m_c1 < 65535) ? m_c1 + 1 : m_c1;
                    m_s1 = (m_s1 < 3) ? m_s1 + 1 : m_s1;
                end
            end
        end
    end

    // Monitor: whatever sits in the output register must be the oldest
    // expected beat; it leaves the scoreboard on the consumer handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("s_out_valid", s_out_valid, q.size() != 0);
            run_len = out_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (out_valid && q.size() != 0) begin
                chk("out_data", out_data, int'(q[0][W-1:0]));
                chk("out_src", out_src, int'(q[0][W]));
                chk("s_out_data", s_out_data, int'(q[0][W-1:0]));
                if (out_ready) begin
                    log_src.push_back(q[0][W]);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Source driver: present the queue head, hold it until accepted.
    always @(posedge clk) begin
        #1;
        if (pacc0 && sq0.size() != 0) void'(sq0.pop_front());
        if (pacc1 && sq1.size() != 0) void'(sq1.pop_front());
        if (!(in0_valid && !pacc0) || sq0.size() == 0)
            in0_valid = sq0.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0);
        if (!(in1_valid && !pacc1) || sq1.size() == 0)
            in1_valid = sq1.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0);
        in0_data = (sq0.size() != 0) ? sq0[0] : '0;
        in1_data = (sq1.size() != 0) ? sq1[0] : '0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        bit done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (sq0.size() == 0 && sq1.size() == 0 && q.size() == 0 &&
                !in0_valid && !in1_valid) done = 1;
            else tick(1);
        end
        chk("drain_timeout", done, 1);
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    endtask

    initial begin
        #22 rst_n = 1'b1;
        tick(1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cnt0", cnt0, 0);

        // Reset mid-beat.
        out_ready = 1'b0;
        sq0.push_back(8'h11);
        tick(3);
        chk("held_11", out_data, 8'h11);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cnt0", cnt0, 0);
        chk("async_rst_s_cnt0", s_cnt0, 0);
        sq0.push_back(8'h21);
        sq1.push_back(8'h31);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("post_rst_sel", sel, 0);
        drain();

        // Alternation from a known turn (tie goes to in0 after a reset).
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        log_src.delete();
        for (int k = 0; k < 3; k++) begin
            sq0.push_back(8'hA0 + 8'(2 * k));
            sq1.push_back(8'hB0 + 8'(2 * k + 1));
        end
        drain();
        chk("alt_len", log_src.size(), 6);
        for (int k = 0; k < 6 && k < log_src.size(); k++)
            chk("alt_src", log_src[k], k % 2);
        chk("alt_cnt0", cnt0, 3);
        chk("alt_cnt1", cnt1, 3);

        // Backpressure on a lone in1 beat.
        clear_cnt();
        out_ready = 1'b0;
        sq1.push_back(8'h5C);
        tick(6);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'h5C);
        chk("bp_cnt1", cnt1, 1);
        drain();

        // Full throughput stream from in0.
        clear_cnt();
        max_run = 0;
        for (int k = 1; k <= 8; k++) sq0.push_back(8'(k));
        drain();
        chk("tp_run", max_run, 8);
        chk("tp_cnt0", cnt0, 8);
        chk("tp_s_cnt0", s_cnt0, 3);

        // Tie after solo traffic: in0 took the last grant, so in1 wins.
        sq0.push_back(8'h44);
        tick(3);
        log_src.delete();
        sq0.push_back(8'h45);
        sq1.push_back(8'h55);
        drain();
        chk("tie_len", log_src.size(), 2);
        if (log_src.size() != 0) chk("tie_first", log_src[0], 1);

        // Saturation and clear colliding with an accept.
        clear_cnt();
        for (int k = 0; k < 5; k++) sq0.push_back(8'h60 + 8'(k));
        drain();
        chk("sat_s_cnt0", s_cnt0, 3);
        chk("sat_cnt0", cnt0, 5);
        sq0.push_back(8'h70);
        tick(1);
        cnt_clr = 1'b1;
        chk("clr_collide_valid", in0_valid & in0_ready, 1);
        tick(1);
        cnt_clr = 1'b0;
        chk("clr_s_cnt0", s_cnt0, 0);
        chk("clr_cnt0", cnt0, 0);
        drain();

        // Random traffic with gaps, backpressure and occasional clears.
        gap_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (sq0.size() < 3 && $urandom_range(0, 1) != 0) sq0.push_back(8'($urandom));
            if (sq1.size() < 3 && $urandom_range(0, 1) != 0) sq1.push_back(8'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            cnt_clr   = $urandom_range(0, 39) == 0;
            tick(1);
        end
        cnt_clr = 1'b0;
        gap_en  = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
